// File: rtl/mips32_loader_pkg.sv
// Shared types and constants for the mips32 program loader.
// Optional feature macro: MIPS32_LOADER_CHECKSUM_EN (adds CHK byte and ERR path).
package mips32_loader_pkg;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte lane of the last data byte of a word (big-endian: lane 0 is [31:24]).
  localparam logic [1:0] LAST_LANE = 2'd3;

  // A COUNT byte of zero encodes a full block of 256 words.
  localparam logic [8:0] MAX_WORDS = 9'd256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Decode the COUNT byte into a word count.
  function automatic logic [8:0] word_count(input logic [7:0] b);
    return (b == 8'd0) ? MAX_WORDS : {1'b0, b};
  endfunction

endpackage

// File: rtl/mips32_loader_word_asm.sv
// Big-endian 4-byte word assembler: shifts bytes in MSB-first, counts lanes
// and flags (registered) the cycle after the 4th byte lands.
module mips32_loader_word_asm
  import mips32_loader_pkg::*;
(
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_last_lane,
  output logic        o_word_ready
);

  logic [31:0] r_word;
  logic [1:0]  r_lane;
  logic        r_word_ready;

  // Shift bytes into the word, track the lane and flag a completed word.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_word       <= 32'd0;
      r_lane       <= 2'd0;
      r_word_ready <= 1'b0;
    end else begin
      r_word_ready <= i_shift && (r_lane == LAST_LANE);
      if (i_clr) begin
        r_lane <= 2'd0;
      end else if (i_shift) begin
        r_word <= {r_word[23:0], i_byte};
        r_lane <= r_lane + 2'd1;
      end
    end
  end

  assign o_word       = r_word;
  assign o_last_lane  = (r_lane == LAST_LANE);
  assign o_word_ready = r_word_ready;

endmodule

// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader for the mips32_core memory. Parses
// SYNC/ADDR_HI/ADDR_LO/COUNT/data frames, writes words, and holds the
// core in reset until a frame completes.
// Optional feature macro: MIPS32_LOADER_CHECKSUM_EN (XOR CHK byte, err output).
module mips32_prog_loader
  import mips32_loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  logic              r_in_ready;
  logic [7:0]        r_addr_hi;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0]        r_count;
  logic              r_core_rst_n;
  logic              r_done;

  logic              w_accept;
  logic              w_sync;
  logic              w_restart;
  logic              w_shift;
  logic              w_last_lane;
  logic              w_word_ready;
  logic [31:0]       w_word;

  assign w_accept  = in_valid && r_in_ready;
  assign w_sync    = w_accept && (in_data == SYNC_BYTE);
  assign w_restart = w_sync && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                (r_state == ST_ERR));
  assign w_shift   = w_accept && (r_state == ST_DATA);

  mips32_loader_word_asm u_word_asm (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .i_clr        (w_restart),
    .i_shift      (w_shift),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_last_lane  (w_last_lane),
    .o_word_ready (w_word_ready)
  );

`ifdef MIPS32_LOADER_CHECKSUM_EN
  logic [7:0] r_chk;
  logic       r_err;

  // Running XOR over every header and data byte of the current frame.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_chk <= 8'd0;
    end else if (w_restart) begin
      r_chk <= 8'd0;
    end else if (w_accept && ((r_state == ST_ADDR_HI) || (r_state == ST_ADDR_LO) ||
                              (r_state == ST_COUNT) || (r_state == ST_DATA))) begin
      r_chk <= r_chk ^ in_data;
    end
  end
`endif

  // Frame-parsing FSM with address/count counters and registered status outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_addr_hi    <= 8'd0;
      r_addr       <= '0;
      r_count      <= 9'd0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_in_ready <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_sync) r_state <= ST_ADDR_HI;
        end
        ST_ADDR_HI: begin
          if (w_accept) begin
            r_addr_hi <= in_data;
            r_state   <= ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          if (w_accept) begin
            r_addr  <= ADDR_W'({r_addr_hi, in_data});
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (w_accept) begin
            r_count <= word_count(in_data);
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          // The 4th byte completes the word; stall the source for the write cycle.
          if (w_accept && w_last_lane) begin
            r_state    <= ST_WRITE;
            r_in_ready <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (r_count == 9'd1) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
            r_state      <= ST_CHECK;
`else
            r_state      <= ST_DONE;
            r_core_rst_n <= 1'b1;
            r_done       <= 1'b1;
`endif
          end else begin
            r_count <= r_count - 9'd1;
            r_addr  <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_state <= ST_DATA;
          end
        end
`ifdef MIPS32_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_accept) begin
            if (in_data == r_chk) begin
              r_state      <= ST_DONE;
              r_core_rst_n <= 1'b1;
              r_done       <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        ST_DONE, ST_ERR: begin
          // A new frame re-arms the core reset and clears the status flags.
          if (w_sync) begin
            r_state      <= ST_ADDR_HI;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            r_err        <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign mem_we     = w_word_ready;
  assign mem_addr   = r_addr;
  assign mem_wdata  = w_word;
  assign core_rst_n = r_core_rst_n;
  assign done       = r_done;
`ifdef MIPS32_LOADER_CHECKSUM_EN
  assign err        = r_err;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Scoreboard bench for mips32_prog_loader: stimulus pushes expected word
// writes, a negedge monitor pops and compares them on every mem_we.
module tb_mips32_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        done;
  logic        err;

  always #5 clk1 = ~clk1;

  mips32_prog_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write is popped from the scoreboard; in_ready must be
  // low exactly in write cycles and mem_we must never last two cycles.
  always @(negedge clk1) begin
    wr_t e;
    if (mon_en) begin
      if (mem_we) begin
        chk("in_ready_in_write", {31'd0, in_ready}, 32'd0);
        chk("we_pulse_width", {31'd0, prev_we}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                   mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          $display("write addr=%03h data=%08h (expected %03h %08h)",
                   mem_addr, mem_wdata, e.a, e.d);
          chk("write_addr", {22'd0, mem_addr}, {22'd0, e.a});
          chk("write_data", mem_wdata, e.d);
        end
      end else begin
        chk("in_ready_outside_write", {31'd0, in_ready}, 32'd1);
      end
      prev_we = mem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk1);
      t++;
    end
    if (t >= 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready 0 for 20 cycles, expected 1");
    end
    @(posedge clk1);
    #1;
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input int n,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input logic [7:0] chk_byte, input bit reload_check);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{a: a[9:0] + 10'(i), d: (i == 0) ? w0 : w1});
    end
    send_byte(8'hA5);
    if (reload_check) begin
      chk("reload_core_rst_n_on_sync", {31'd0, core_rst_n}, 32'd0);
      chk("reload_done_on_sync", {31'd0, done}, 32'd0);
    end
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(8'(n));
    for (int j = 0; j < n; j++) begin
      w = (j == 0) ? w0 : w1;
      for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
    end
`ifdef MIPS32_LOADER_CHECKSUM_EN
    send_byte(chk_byte);
`endif
    go_idle();
  endtask

  task automatic check_status(input string tag, input logic e_done,
                              input logic e_err, input logic e_core);
    repeat (2) @(negedge clk1);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
    chk({tag, "_core_rst_n"}, {31'd0, core_rst_n}, {31'd0, e_core});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk1);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    mon_en = 1'b1;

    // Nominal frame preceded by garbage, valid held high throughout
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(16'h0000, 2, 32'h20190200, 32'h20180300, 8'h02, 1'b0);
    check_status("nominal", 1'b1, 1'b0, 1'b1);

`ifdef MIPS32_LOADER_CHECKSUM_EN
    // Bad checksum: words still written, err set, core kept in reset
    send_frame(16'h0000, 2, 32'h20190200, 32'h20180300, 8'h03, 1'b0);
    check_status("badchk", 1'b0, 1'b1, 1'b0);
`endif

    // Wraparound from the top word to word 0
    send_frame(16'h03FF, 2, 32'h11111111, 32'h22222222, 8'hFE, 1'b0);
    check_status("wrap", 1'b1, 1'b0, 1'b1);

    // Reset after the 2nd data byte
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h19);
    go_idle();
    @(negedge clk1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
    mon_en = 1'b1;
    send_frame(16'h0000, 2, 32'h20190200, 32'h20180300, 8'h02, 1'b0);
    check_status("after_reset", 1'b1, 1'b0, 1'b1);

    // Reload after DONE: core reset and done drop on sync, return at new DONE
    send_frame(16'h0010, 1, 32'hDEADBEEF, 32'h0, 8'h33, 1'b1);
    check_status("reload", 1'b1, 1'b0, 1'b1);

    repeat (5) @(negedge clk1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
